// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch-stage program counter for the pipelined MIPS core.
//
// Holds the fetch PC and produces PC+STEP. Each edge it picks the next PC
// from one of: the sequential step, a branch/jump redirect, the exception
// entry, or the ERET return address. A redirect that arrives while the
// decode stage is stalling is held in a one-entry buffer, so it is applied
// on the first cycle the stall drops instead of being lost.
//
// Optional feature: define PC_FETCH_CNT_EN to add the fetch_cnt output.
// It is a 32-bit wrapping count of edges on which pc_out was updated.
//
// Ports:
//   clk            in   clock; all state changes on the rising edge
//   reset          in   synchronous, active-high
//   stall          in   hold the PC (hazard stall from decode)
//   redirect_valid in   branch/jump taken this cycle
//   redirect_pc    in   redirect target
//   exc_req        in   enter the exception handler (highest priority)
//   eret_req       in   return from exception to epc_in
//   epc_in         in   return address from CP0
//   pc_out         out  current fetch PC (registered)
//   pc_plus_step   out  pc_out + STEP, modulo 2^WIDTH
//   pend_valid     out  a buffered redirect is waiting
//   pc_misaligned  out  pc_out[1:0] != 0 (flag only; CP0 decides)
//   fetch_cnt      out  update count (only with PC_FETCH_CNT_EN)
module pc_sequencer #(
  parameter int unsigned          WIDTH    = 32,
  parameter int unsigned          STEP     = 4,
  parameter logic [WIDTH-1:0]     RESET_PC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0]     EXC_PC   = WIDTH'(32'h0000_4180)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             pend_valid,
  output logic             pc_misaligned
`ifdef PC_FETCH_CNT_EN
  ,
  output logic [31:0]      fetch_cnt
`endif
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt;
  logic [WIDTH-1:0] r_pend_pc, w_pend_pc_nxt;
  logic [WIDTH-1:0] w_pc_plus;
  logic             w_pc_upd;

  assign w_pc_plus     = r_pc + WIDTH'(STEP);
  assign pc_out        = r_pc;
  assign pc_plus_step  = w_pc_plus;
  assign pend_valid    = (r_state == PEND);
  assign pc_misaligned = |r_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_pend_pc <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_pc_nxt;
    end
  end

  // Next-PC selection, first match wins. Leaving PEND is enough to discard a
  // buffered target; pend_pc itself is simply overwritten by the next one.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pend_pc_nxt = r_pend_pc;
    w_pc_upd      = 1'b0;
    if (exc_req) begin
      w_pc_nxt    = EXC_PC;
      w_state_nxt = IDLE;
      w_pc_upd    = 1'b1;
    end else if (eret_req) begin
      w_pc_nxt    = epc_in;
      w_state_nxt = IDLE;
      w_pc_upd    = 1'b1;
    end else if (stall) begin
      // Newest redirect wins the single buffer slot.
      if (redirect_valid) begin
        w_pend_pc_nxt = redirect_pc;
        w_state_nxt   = PEND;
      end
    end else if (redirect_valid) begin
      // A live redirect is younger than any buffered one.
      w_pc_nxt    = redirect_pc;
      w_state_nxt = IDLE;
      w_pc_upd    = 1'b1;
    end else if (r_state == PEND) begin
      w_pc_nxt    = r_pend_pc;
      w_state_nxt = IDLE;
      w_pc_upd    = 1'b1;
    end else begin
      w_pc_nxt = w_pc_plus;
      w_pc_upd = 1'b1;
    end
  end

`ifdef PC_FETCH_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk) begin
    if (reset)         r_fetch_cnt <= '0;
    else if (w_pc_upd) r_fetch_cnt <= r_fetch_cnt + 32'd1;
  end

  assign fetch_cnt = r_fetch_cnt;
`else
  // Update strobe only feeds the optional counter.
  logic w_unused;
  assign w_unused = w_pc_upd;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-stage program counter for the pipelined MIPS core.
- Holds the PC register and produces PC+STEP; the sequential PC+4 adder is folded in.
- Selects the next PC from the sequential step, branch/jump redirect, exception entry or ERET return.
- Buffers one redirect that arrives during a stall, so decode-stage redirects are never lost.

Parameters:
- WIDTH, 32, PC width in bits.
- STEP, 4, sequential increment in bytes.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_PC, 32'h0000_4180, exception handler entry address.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- stall  input  1  hold the PC (hazard stall from the decode stage).
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  WIDTH  redirect target.
- exc_req  input  1  enter the exception handler.
- eret_req  input  1  return from exception.
- epc_in  input  WIDTH  return address from CP0.
- pc_out  output  WIDTH  current fetch PC (registered).
- pc_plus_step  output  WIDTH  pc_out + STEP (combinational).
- pend_valid  output  1  a buffered redirect is waiting.
- pc_misaligned  output  1  pc_out[1:0] != 2'b00.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset; it is sampled only on the rising edge of clk.
- Reset values: pc_out = RESET_PC; pend_valid = 0; pend_pc = 0; pc_misaligned = (RESET_PC[1:0] != 0); fetch_cnt = 0 when the optional feature is present.
- Arithmetic: pc_plus_step = pc_out + STEP, truncated to WIDTH bits. Wrap-around is modulo 2^WIDTH, e.g. 32'hFFFF_FFFC + 4 = 32'h0000_0000. No overflow flag.
- State machine: two states, IDLE (pend_valid = 0) and PEND (pend_valid = 1). The internal register pend_pc holds the buffered target.
- Next-PC priority, first match wins on each rising edge:
  1. reset: pc_out <= RESET_PC; state -> IDLE.
  2. exc_req: pc_out <= EXC_PC; pending redirect discarded; state -> IDLE. Overrides stall, eret_req and any redirect.
  3. eret_req: pc_out <= epc_in; pending discarded; state -> IDLE. Overrides stall.
  4. stall = 1:
     - pc_out holds.
     - If redirect_valid: pend_pc <= redirect_pc; state -> PEND. A newer redirect overwrites an older pending one.
     - Otherwise the state holds.
  5. stall = 0, redirect_valid = 1: pc_out <= redirect_pc; state -> IDLE. A live redirect beats a pending one.
  6. stall = 0, state PEND: pc_out <= pend_pc; state -> IDLE.
  7. Otherwise: pc_out <= pc_plus_step.
- Latency: one cycle from any request to the new pc_out. A buffered redirect applies on the first non-stall edge.
- Reset mid-operation: pending is discarded and the PC goes to RESET_PC regardless of the other inputs.
- exc_req and eret_req together: exc_req wins.
- Misalignment: pc_misaligned is a pure combinational decode of pc_out. The block does not trap; a misaligned target is loaded as given and CP0 decides.
- Unknown inputs: no X may propagate to pc_out while reset = 1.

Optional Feature:
- Macro: PC_FETCH_CNT_EN.
- Defined: adds output fetch_cnt, 32 bits, reset to 0.
  - Increments by 1 (wrapping) on every edge where pc_out is updated, i.e. priority cases 2, 3, 5, 6 and 7.
  - Holds during stall and during reset.
- Not defined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
1. Reset then 3 free-running cycles -> pc_out 0x3000, 0x3004, 0x3008, 0x300C; pc_plus_step tracks +4; pend_valid = 0.
2. pc_out = 0x3010, stall = 1 with redirect_valid = 1, redirect_pc = 0x3100 for one cycle, stall held 2 more cycles, then released -> pc_out holds 0x3010 with pend_valid = 1 during the stall; next edge pc_out = 0x3100, pend_valid = 0.
3. Stalled with 0x3100 pending, then exc_req = 1 -> pc_out = 0x4180, pend_valid = 0; next cycle with eret_req = 1, epc_in = 0x3024 -> pc_out = 0x3024.
4. Two redirects during one stall (0x3200, then 0x3300), then stall released with a live redirect 0x3400 -> pc_out = 0x3400. Repeat without the live redirect -> pc_out = 0x3300.
5. Redirect to 0xFFFF_FFFC then a free cycle -> pc_out = 0x0000_0000. Redirect to 0x3002 -> pc_misaligned = 1.
6. With PC_FETCH_CNT_EN defined: 5 free cycles, 2 stall cycles, 1 exception -> fetch_cnt = 6. Assert reset mid-stall with a redirect pending -> pc_out = 0x3000, fetch_cnt = 0, pend_valid = 0.
